// File: rtl/mix_column_seq.sv
// mix_column_seq: sequential AES MixColumns for one 32-bit column.
// A single combinational GF(2^8) multiplier (poly 0x11B) is reused for all
// 16 coefficient-by-byte products, one product per CALC cycle.
// Optional macro INV_MIX_EN adds the 'inv' port selecting InvMixColumns.
module mix_column_seq #(
  parameter int COL_W = 32,   // fixed at 32
  parameter int CNT_W = 4     // 16 product steps
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COL_W-1:0] in_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_col,
`ifdef INV_MIX_EN
  input  logic             inv,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [COL_W-1:0]   col_reg;
  logic [7:0]         acc_reg;
  logic [23:0]        shadow_reg;      // result bytes 0..2; byte 3 goes straight to out_col
  logic [COL_W-1:0]   out_col_reg;
`ifdef INV_MIX_EN
  logic               inv_reg;
`endif

  logic               accept;
  logic [1:0]         row;
  logic [1:0]         jdx;
  logic [1:0]         vidx;
  logic [7:0]         coef;
  logic [7:0]         col_bytes [0:3];
  logic [7:0]         sel_byte;
  logic [7:0]         xt [0:7];        // sel_byte * x^k
  logic [7:0]         pp [0:7];        // partial products gated by coef bits
  logic [7:0]         prod;
  logic [7:0]         acc_sum;

  assign accept = in_valid && (state_reg == IDLE);
  assign row    = cnt_reg[3:2];
  assign jdx    = cnt_reg[1:0];
  assign vidx   = jdx - row;           // (j - r) mod 4 via 2-bit wrap

  // Split the latched column into bytes, s0 in the top byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bytes
      assign col_bytes[gi] = col_reg[COL_W-1-8*gi -: 8];
    end
  endgenerate

  assign sel_byte = col_bytes[jdx];

  // Coefficient from the rotated row vector.
  always_comb begin
    coef = 8'h01;
`ifdef INV_MIX_EN
    if (inv_reg) begin
      case (vidx)
        2'd0:    coef = 8'h0e;
        2'd1:    coef = 8'h0b;
        2'd2:    coef = 8'h0d;
        default: coef = 8'h09;
      endcase
    end else begin
      case (vidx)
        2'd0:    coef = 8'h02;
        2'd1:    coef = 8'h03;
        default: coef = 8'h01;
      endcase
    end
`else
    case (vidx)
      2'd0:    coef = 8'h02;
      2'd1:    coef = 8'h03;
      default: coef = 8'h01;
    endcase
`endif
  end

  // Shift-and-add multiplier: xtime chain, reduced by 0x1B at each step.
  assign xt[0] = sel_byte;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_xtime
      assign xt[gi+1] = {xt[gi][6:0], 1'b0} ^ (xt[gi][7] ? 8'h1b : 8'h00);
    end
    for (gi = 0; gi < 8; gi++) begin : g_pp
      assign pp[gi] = coef[gi] ? xt[gi] : 8'h00;
    end
  endgenerate

  // Fold the partial products into the product byte.
  always_comb begin
    prod = 8'h00;
    for (int k = 0; k < 8; k++) begin
      prod = prod ^ pp[k];
    end
  end

  assign acc_sum = (jdx == 2'd0) ? prod : (acc_reg ^ prod);

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = CALC;
          cnt_next   = '0;
        end
      end
      CALC: begin
        busy     = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == 4'd15) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, input latch, accumulator and final result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      col_reg     <= '0;
      acc_reg     <= 8'h00;
      out_col_reg <= '0;
`ifdef INV_MIX_EN
      inv_reg     <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        col_reg <= in_col;
`ifdef INV_MIX_EN
        inv_reg <= inv;
`endif
      end
      if (state_reg == CALC) begin
        acc_reg <= acc_sum;
        if (cnt_reg == 4'd15) out_col_reg <= {shadow_reg, acc_sum};
      end
    end
  end

  // Shadow bytes for rows 0..2, written when the row's last product lands.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_reg[23-8*gi -: 8] <= 8'h00;
        end else if (state_reg == CALC && jdx == 2'd3 && row == 2'(gi)) begin
          shadow_reg[23-8*gi -: 8] <= acc_sum;
        end
      end
    end
  endgenerate

  assign out_col = out_col_reg;

endmodule

// File: tb/tb_mix_column_seq.sv
// Testbench for mix_column_seq: known-answer table, hand-written corner
// sequences (stall, back-to-back, mid-column reset) and random columns
// checked against a matrix-form MixColumns model.
module tb_mix_column_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_col;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_col;
  logic        busy;
  logic        inv_in;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mix_column_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_col    (in_col),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
`ifdef INV_MIX_EN
    .inv       (inv_in),
`endif
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] col;
    logic        inv;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  // GF(2^8) multiply, bit by bit with reduction by 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Full-matrix MixColumns / InvMixColumns.
  function automatic logic [31:0] mix_model(input logic [31:0] c, input logic iv);
    logic [7:0] fm [4][4];
    logic [7:0] im [4][4];
    logic [7:0] s [4];
    logic [7:0] b;
    logic [31:0] r;
    fm = '{'{8'h02,8'h03,8'h01,8'h01}, '{8'h01,8'h02,8'h03,8'h01},
           '{8'h01,8'h01,8'h02,8'h03}, '{8'h03,8'h01,8'h01,8'h02}};
    im = '{'{8'h0e,8'h0b,8'h0d,8'h09}, '{8'h09,8'h0e,8'h0b,8'h0d},
           '{8'h0d,8'h09,8'h0e,8'h0b}, '{8'h0b,8'h0d,8'h09,8'h0e}};
    s[0] = c[31:24]; s[1] = c[23:16]; s[2] = c[15:8]; s[3] = c[7:0];
    r = 32'h0;
    for (int row = 0; row < 4; row++) begin
      b = 8'h00;
      for (int j = 0; j < 4; j++) b = b ^ gm(iv ? im[row][j] : fm[row][j], s[j]);
      r = (r << 8) | 32'(b);
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one column starting at a negedge; returns at the negedge after the handshake.
  task automatic run_col(input logic [31:0] col, input logic iv, input logic [31:0] exp,
                         input int stall, input bit garbage, input bit hold_next,
                         input logic [31:0] next_col, input string nm);
    int n;
    bit seen;
    check({nm, "_rdy_before"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_col    = col;
    inv_in    = iv;
    out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    if (hold_next) begin
      in_valid = 1'b1;
      in_col   = next_col;
    end else begin
      in_valid = 1'b0;
      in_col   = $urandom;
    end
    seen = 0;
    n = 0;
    while (!seen && n < 40) begin
      if (garbage) begin
        in_valid = 1'($urandom);
        in_col   = $urandom;
        inv_in   = 1'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
      check({nm, "_rdy_low"}, 32'(in_ready), 32'd0);
      check({nm, "_busy"}, 32'(busy), 32'd1);
      if (out_valid) seen = 1;
    end
    if (garbage) in_valid = 1'b0;
    check({nm, "_latency"}, 32'(n), 32'd16);
    check({nm, "_out_col"}, out_col, exp);
    for (int k = 0; k < stall; k++) begin
      @(posedge clk);
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({nm, "_hold_col"}, out_col, exp);
      check({nm, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({nm, "_vld_clear"}, 32'(out_valid), 32'd0);
    check({nm, "_rdy_back"}, 32'(in_ready), 32'd1);
    $display("col %s in=%h inv=%0d out=%h exp=%h lat=%0d", nm, col, iv, out_col, exp, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rc;
    logic        ri;
    rst_n = 1'b0; in_valid = 1'b0; in_col = 32'h0; out_ready = 1'b1; inv_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_col", out_col, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer table.
    tbl.push_back('{32'hdb135345, 1'b0, 32'h8e4da1bc});
    tbl.push_back('{32'hf20a225c, 1'b0, 32'h9fdc589d});
    tbl.push_back('{32'hd4d4d4d5, 1'b0, 32'hd5d5d7d6});
    tbl.push_back('{32'h2d26314c, 1'b0, 32'h4d7ebdf8});
    tbl.push_back('{32'h00000000, 1'b0, 32'h00000000});
`ifdef INV_MIX_EN
    tbl.push_back('{32'h8e4da1bc, 1'b1, 32'hdb135345});
    tbl.push_back('{32'h9fdc589d, 1'b1, 32'hf20a225c});
    tbl.push_back('{32'hdb135345, 1'b0, 32'h8e4da1bc});
`endif
    foreach (tbl[i]) run_col(tbl[i].col, tbl[i].inv, tbl[i].exp, 0, 0, 0, 32'h0, $sformatf("tbl%0d", i));

    // Stall for 5 cycles in DONE.
    run_col(32'hf20a225c, 1'b0, 32'h9fdc589d, 5, 0, 0, 32'h0, "stall");

    // Back-to-back with in_valid held: second accept on the cycle after handshake.
    run_col(32'h01010101, 1'b0, 32'h01010101, 0, 0, 1, 32'hc6c6c6c6, "b2b_a");
    run_col(32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6, 0, 0, 0, 32'h0, "b2b_b");

    // Reset at cnt = 7 aborts the column.
    in_valid = 1'b1; in_col = 32'hdb135345; inv_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_col", out_col, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    run_col(32'hd4d4d4d5, 1'b0, 32'hd5d5d7d6, 0, 0, 0, 32'h0, "post_rst");

    // Garbage on in_valid / in_col during CALC.
    run_col(32'hdb135345, 1'b0, 32'h8e4da1bc, 1, 1, 0, 32'h0, "garbage");

    // Random columns against the matrix model.
    for (int t = 0; t < 20; t++) begin
      rc = $urandom;
`ifdef INV_MIX_EN
      ri = 1'($urandom);
`else
      ri = 1'b0;
`endif
      run_col(rc, ri, mix_model(rc, ri), int'($urandom_range(0, 2)), 1, 0, 32'h0,
              $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
